// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//
// Watches three lamp signals and checks that they step red -> yellow -> green
// -> red, holding each phase for exactly DWELL consecutive samples. Once the
// monitor has seen a phase change it locks on (SYNC). Any sequence or timing
// violation raises a sticky flag and drops the monitor back to UNSYNC so that
// it can lock on again. Completed, error-free cycles are counted.
//
// Parameters
//   DWELL  required consecutive samples per lamp phase
//   CNT_W  width of the completed-cycle counter (saturating)
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous, active-high reset
//   red/yellow/green    lamp samples, synchronous to clk
//   clr_err             clears the sticky error flags
//   phase[1:0]          registered decoded phase (00 off/illegal, 01 red,
//                       10 yellow, 11 green)
//   in_sync             monitor is locked to the lamp sequence
//   err_onehot          more than one lamp was lit (sticky)
//   err_seq             illegal phase order (sticky)
//   err_dwell           phase held too short or too long (sticky)
//   err_any             OR of the three error flags
//   cycles[CNT_W-1:0]   completed error-free red-yellow-green cycles
//
// Optional feature: define TRAFFIC_LIGHT_MONITOR_FIRST_ERR_EN to add
//   first_err[1:0]      first error seen while no flag was set
//                       (01 onehot, 10 seq, 11 dwell; onehot > seq > dwell)
//   first_phase[1:0]    previous phase at the moment of that error
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             in_sync,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_dwell,
  output logic             err_any,
  output logic [CNT_W-1:0] cycles
`ifdef TRAFFIC_LIGHT_MONITOR_FIRST_ERR_EN
  ,
  output logic [1:0]       first_err,
  output logic [1:0]       first_phase
`endif
);

  typedef enum logic [1:0] {
    PH_OFF = 2'b00,
    PH_RED = 2'b01,
    PH_YEL = 2'b10,
    PH_GRN = 2'b11
  } phase_e;

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_SYNC   = 1'b1
  } state_e;

  localparam int               DW_W    = $clog2(DWELL + 1);
  localparam logic [DW_W-1:0]  DWELL_V = DW_W'(DWELL);

  // Only legal successor of each lit phase; off has none.
  function automatic phase_e succ(input phase_e p);
    case (p)
      PH_RED:  succ = PH_YEL;
      PH_YEL:  succ = PH_GRN;
      PH_GRN:  succ = PH_RED;
      default: succ = PH_OFF;
    endcase
  endfunction

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic              err_oh_q, err_oh_d;
  logic              err_seq_q, err_seq_d;
  logic              err_dw_q, err_dw_d;
`ifdef TRAFFIC_LIGHT_MONITOR_FIRST_ERR_EN
  logic [1:0]        first_err_q, first_err_d;
  logic [1:0]        first_phase_q, first_phase_d;
`endif

  logic   illegal;
  phase_e cur;
  logic   new_oh, new_seq, new_dw;

  // Sample decode: illegal samples register as off.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    illegal = (red & yellow) | (red & green) | (yellow & green);
    cur     = PH_OFF;
    if (!illegal) begin
      if (red)         cur = PH_RED;
      else if (yellow) cur = PH_YEL;
      else if (green)  cur = PH_GRN;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = cur;
    dwell_d  = dwell_q;
    cycles_d = cycles_q;
    new_oh   = 1'b0;
    new_seq  = 1'b0;
    new_dw   = 1'b0;

    if (illegal) begin
      // A multi-lamp sample is not a phase at all, so only the one-hot error
      // applies; sequence and dwell are not judged against it.
      new_oh  = 1'b1;
      state_d = ST_UNSYNC;
      dwell_d = '0;
    end else begin
      case (state_q)
        ST_UNSYNC: begin
          if (cur != phase_q && cur != PH_OFF) begin
            state_d = ST_SYNC;
            dwell_d = DW_W'(1);
          end
        end
        ST_SYNC: begin
          if (cur == phase_q) begin
            if (dwell_q == DWELL_V) new_dw  = 1'b1;  // overstay
            else                    dwell_d = dwell_q + 1'b1;
          end else begin
            new_seq = (cur != succ(phase_q));
            new_dw  = (dwell_q < DWELL_V);           // understay
            if (!new_seq && !new_dw) begin
              dwell_d = DW_W'(1);
              // A clean green->red change closes one full cycle.
              if (phase_q == PH_GRN && cycles_q != '1) cycles_d = cycles_q + 1'b1;
            end
          end
          if (new_seq || new_dw) begin
            state_d = ST_UNSYNC;
            dwell_d = '0;
          end
        end
        default: state_d = ST_UNSYNC;
      endcase
    end

    // A fresh error outranks a simultaneous clear.
    err_oh_d  = (err_oh_q  & ~clr_err) | new_oh;
    err_seq_d = (err_seq_q & ~clr_err) | new_seq;
    err_dw_d  = (err_dw_q  & ~clr_err) | new_dw;
  end

`ifdef TRAFFIC_LIGHT_MONITOR_FIRST_ERR_EN
  always_comb begin
    first_err_d   = first_err_q;
    first_phase_d = first_phase_q;
    // Capture while no flag is held; a clear in this cycle counts as empty.
    if ((new_oh || new_seq || new_dw) && (!err_any || clr_err)) begin
      first_err_d   = new_oh ? 2'b01 : (new_seq ? 2'b10 : 2'b11);
      first_phase_d = phase_q;
    end else if (clr_err) begin
      first_err_d   = 2'b00;
      first_phase_d = 2'b00;
    end
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_UNSYNC;
      phase_q   <= PH_OFF;
      dwell_q   <= '0;
      cycles_q  <= '0;
      err_oh_q  <= 1'b0;
      err_seq_q <= 1'b0;
      err_dw_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      dwell_q   <= dwell_d;
      cycles_q  <= cycles_d;
      err_oh_q  <= err_oh_d;
      err_seq_q <= err_seq_d;
      err_dw_q  <= err_dw_d;
    end
  end

`ifdef TRAFFIC_LIGHT_MONITOR_FIRST_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      first_err_q   <= 2'b00;
      first_phase_q <= 2'b00;
    end else begin
      first_err_q   <= first_err_d;
      first_phase_q <= first_phase_d;
    end
  end

  assign first_err   = first_err_q;
  assign first_phase = first_phase_q;
`endif

  assign phase      = phase_q;
  assign in_sync    = (state_q == ST_SYNC);
  assign err_onehot = err_oh_q;
  assign err_seq    = err_seq_q;
  assign err_dwell  = err_dw_q;
  assign err_any    = err_oh_q | err_seq_q | err_dw_q;
  assign cycles     = cycles_q;

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter DWELL, default 4, is the required number of consecutive samples per lamp phase.
REQ-002 Parameter CNT_W, default 8, is the width of the completed-cycle counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 red, yellow, green  input  1 each  lamp signals under observation, synchronous to clk.
REQ-006 clr_err  input  1  clears sticky error flags.
REQ-007 phase  output  2  registered decoded phase: 00 off/illegal, 01 red, 10 yellow, 11 green.
REQ-008 in_sync  output  1  monitor is locked to the lamp sequence.
REQ-009 err_onehot, err_seq, err_dwell  output  1 each  sticky error flags.
REQ-010 err_any  output  1  OR of the three error flags.
REQ-011 cycles  output  CNT_W  count of completed, error-free red-yellow-green cycles.

Function
REQ-012 Decode each sample: no lamp -> off; exactly one lamp -> that phase; more than one lamp -> illegal.
REQ-013 The illegal decode SHALL set err_onehot, force in_sync low and register phase=00.
REQ-014 States: UNSYNC and SYNC. Each sample is compared against the registered previous phase; flags and state update at that same edge, visible one cycle after the sample.
REQ-015 UNSYNC: no sequence or dwell checks. Any phase change into red, yellow or green enters SYNC with dwell_cnt=1.
REQ-016 SYNC, same phase sampled again: increment dwell_cnt. A sample that would make dwell_cnt exceed DWELL sets err_dwell (overstay).
REQ-017 SYNC, phase change with dwell_cnt < DWELL: set err_dwell (understay).
REQ-018 SYNC legal transitions are only red->yellow, yellow->green and green->red. Any other change, including to off, sets err_seq.
REQ-019 Any error detected in SYNC returns the monitor to UNSYNC at the same edge, so it resynchronises.
REQ-020 A legal, correctly timed green->red change in SYNC increments cycles. The counter saturates at all-ones.
REQ-021 Error flags are sticky until clr_err. A new error in the same cycle as clr_err wins, and its flag stays 1.
REQ-022 When several errors occur in one sample, all applicable flags are set together.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL clear the following at that edge: phase=00, in_sync=0, all error flags=0, cycles=0, dwell_cnt=0, previous phase=off, state=UNSYNC.
REQ-024 rst has priority over all inputs, including mid-phase and in the same cycle as clr_err.

Configuration
REQ-025 Macro TRAFFIC_LIGHT_MONITOR_FIRST_ERR_EN, when defined, adds outputs first_err[1:0] and first_phase[1:0].
REQ-026 first_err codes are 01 onehot, 10 seq, 11 dwell, with priority onehot > seq > dwell.
REQ-027 first_err and first_phase (the previous phase at the error) SHALL be captured only when err_any is 0. They are cleared by rst or clr_err.
REQ-028 When the macro is undefined, those ports and registers SHALL be absent; all other behaviour is identical.

Verification (DWELL=4)
REQ-029 Release rst; drive off x4, then red, yellow, green x4 each, then red -> in_sync=1 one cycle after the first red sample. No error flags. cycles=1 after the green->red sample.
REQ-030 In SYNC, drive red=green=1 for one cycle -> next cycle: err_onehot=1, err_any=1, in_sync=0, phase=00.
REQ-031 Drive red x4 then green -> err_seq=1. cycles unchanged.
REQ-032 Drive red x3 then yellow -> err_dwell=1 (understay). Separately, drive red x5 -> err_dwell=1 on the fifth red sample.
REQ-033 With err_seq=1, assert clr_err alone -> flags 0 next cycle. Assert clr_err together with a new dwell error -> err_dwell=1.
REQ-034 Assert rst mid-green with errors set and cycles=3 -> all outputs 0 next cycle. With the macro defined: first_err=10 after the REQ-031 stimulus, and it is not overwritten by a later dwell error.
